// File: rtl/tlb_l1.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tlb_l1 : fully-associative 4 KB-page L1 TLB in front of a page walker    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tlb_l1 #(
  parameter int ENTRIES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_vaddr_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_paddr_o,
  output logic        resp_fault_o,
  input  logic        flush_i,
  output logic        ptw_req_valid_o,
  input  logic        ptw_req_ready_i,
  output logic [31:0] ptw_vaddr_o,
  input  logic        ptw_resp_valid_i,
  output logic        ptw_resp_ready_o,
  input  logic [31:0] ptw_pte_i
);

  localparam int c_idx_w = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  localparam logic [2:0] c_idle     = 3'd0;
  localparam logic [2:0] c_lookup   = 3'd1;
  localparam logic [2:0] c_ptw_req  = 3'd2;
  localparam logic [2:0] c_ptw_wait = 3'd3;
  localparam logic [2:0] c_resp     = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [31:0]        r_vaddr;
  logic [ENTRIES-1:0] r_valid;
  logic [19:0]        r_tag [ENTRIES];
  logic [19:0]        r_ppn [ENTRIES];
  logic [c_idx_w-1:0] r_victim;
  logic               r_flush_pend;

  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_paddr;
  logic        r_resp_fault;
  logic        r_ptw_req_valid;
  logic        r_ptw_resp_ready;

  logic        w_req_ready_nxt;
  logic        w_resp_valid_nxt;
  logic [31:0] w_resp_paddr_nxt;
  logic        w_resp_fault_nxt;
  logic        w_ptw_req_valid_nxt;
  logic        w_ptw_resp_ready_nxt;

  logic               w_req_fire;
  logic               w_ptw_req_fire;
  logic               w_pte_fire;
  logic               w_resp_fire;
  logic [ENTRIES-1:0] w_match;
  logic               w_hit;
  logic [19:0]        w_hit_ppn;
  logic [c_idx_w-1:0] w_free_idx;
  logic               w_full;
  logic [c_idx_w-1:0] w_fill_idx;
  logic               w_fill;
  logic               w_unused;

  assign w_req_fire     = req_valid_i & r_req_ready;
  assign w_ptw_req_fire = r_ptw_req_valid & ptw_req_ready_i;
  assign w_pte_fire     = ptw_resp_valid_i & r_ptw_resp_ready;
  assign w_resp_fire    = r_resp_valid & resp_ready_i;
  assign w_unused       = ^ptw_pte_i[11:1];

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
      assign w_match[gi] = r_valid[gi] && (r_tag[gi] == r_vaddr[31:12]);
    end
  endgenerate

  assign w_hit = |w_match;

  // Tags are unique, so at most one match bit is set and an OR-mux suffices.
  always_comb begin
    w_hit_ppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_match[i]) w_hit_ppn = w_hit_ppn | r_ppn[i];
    end
  end

  always_comb begin
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = c_idx_w'(i);
    end
  end

  assign w_full     = &r_valid;
  assign w_fill_idx = w_full ? r_victim : w_free_idx;
  // A flush in the fill cycle or earlier in the walk leaves the entry invalid.
  assign w_fill     = (r_state == c_ptw_wait) && w_pte_fire && ptw_pte_i[0] &&
                      !r_flush_pend && !flush_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_idle;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:     if (w_req_fire)     w_state_nxt = c_lookup;
      c_lookup:                       w_state_nxt = w_hit ? c_resp : c_ptw_req;
      c_ptw_req:  if (w_ptw_req_fire) w_state_nxt = c_ptw_wait;
      c_ptw_wait: if (w_pte_fire)     w_state_nxt = c_resp;
      c_resp:     if (w_resp_fire)    w_state_nxt = c_idle;
      default:                        w_state_nxt = c_idle;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    w_req_ready_nxt      = (w_state_nxt == c_idle);
    w_resp_valid_nxt     = (w_state_nxt == c_resp);
    w_ptw_req_valid_nxt  = (w_state_nxt == c_ptw_req);
    w_ptw_resp_ready_nxt = (w_state_nxt == c_ptw_wait);
    w_resp_paddr_nxt     = r_resp_paddr;
    w_resp_fault_nxt     = r_resp_fault;
    if ((r_state == c_lookup) && w_hit) begin
      w_resp_paddr_nxt = {w_hit_ppn, r_vaddr[11:0]};
      w_resp_fault_nxt = 1'b0;
    end else if ((r_state == c_ptw_wait) && w_pte_fire) begin
      if (ptw_pte_i[0]) begin
        w_resp_paddr_nxt = {ptw_pte_i[31:12], r_vaddr[11:0]};
        w_resp_fault_nxt = 1'b0;
      end else begin
        w_resp_paddr_nxt = '0;
        w_resp_fault_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready      <= 1'b1;
      r_resp_valid     <= 1'b0;
      r_resp_paddr     <= '0;
      r_resp_fault     <= 1'b0;
      r_ptw_req_valid  <= 1'b0;
      r_ptw_resp_ready <= 1'b0;
    end else begin
      r_req_ready      <= w_req_ready_nxt;
      r_resp_valid     <= w_resp_valid_nxt;
      r_resp_paddr     <= w_resp_paddr_nxt;
      r_resp_fault     <= w_resp_fault_nxt;
      r_ptw_req_valid  <= w_ptw_req_valid_nxt;
      r_ptw_resp_ready <= w_ptw_resp_ready_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_vaddr <= '0;
    else if (w_req_fire) r_vaddr <= req_vaddr_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_valid <= '0;
    else if (flush_i) r_valid <= '0;
    else if (w_fill)  r_valid[w_fill_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fill_idx] <= r_vaddr[31:12];
      r_ppn[w_fill_idx] <= ptw_pte_i[31:12];
    end
  end

  // Victim pointer moves only when a fill evicts a live entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_victim <= '0;
    end else if (w_fill && w_full) begin
      r_victim <= (r_victim == c_idx_w'(ENTRIES - 1)) ? '0 : r_victim + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_pend <= 1'b0;
    end else if (w_resp_fire) begin
      r_flush_pend <= 1'b0;
    end else if (flush_i && ((r_state == c_ptw_req) || (r_state == c_ptw_wait))) begin
      r_flush_pend <= 1'b1;
    end
  end

  assign req_ready_o      = r_req_ready;
  assign resp_valid_o     = r_resp_valid;
  assign resp_paddr_o     = r_resp_paddr;
  assign resp_fault_o     = r_resp_fault;
  assign ptw_req_valid_o  = r_ptw_req_valid;
  assign ptw_vaddr_o      = r_vaddr;
  assign ptw_resp_ready_o = r_ptw_resp_ready;

endmodule
`default_nettype wire
